alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU. Adds wider op coverage, a start/valid handshake and an iterative multiplier.
- Sits in the EX stage of the multi-cycle RISC-V core. The control unit issues an operation and stalls until `Valid_o`.
- Single-cycle ops return one clock after acceptance. MUL (and the optional divider) iterate one bit per clock.

Parameters:
- DATA_WIDTH, 32, operand/result width; legal range 16..64, power of two.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount bits taken from B_i.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start_i  input  1  request; accepted only when Ready_o=1.
- ALU_Operation_i  input  4  op code, sampled on accept.
- A_i  input  DATA_WIDTH  operand A, signed, sampled on accept.
- B_i  input  DATA_WIDTH  operand B / immediate, signed, sampled on accept.
- Ready_o  output  1  block can accept a request this cycle.
- Valid_o  output  1  one-cycle pulse: ALU_Result_o/Zero_o updated.
- ALU_Result_o  output  DATA_WIDTH  registered result, held until next completion.
- Zero_o  output  1  registered (ALU_Result_o==0), updated with the result.

Behaviour:
- Op codes:
  - 0000 ADD A+B; 0001 SUB A-B; 0010 AND; 0011 XOR; 1001 OR.
  - 0100 SLT signed (result 1/0); 0101 SLTU unsigned (result 1/0).
  - 0110 SRL; 0111 SRA; 1100 SLL.
  - 1000 LUI {B[DATA_WIDTH-13:0],12'b0}.
  - 1010 MUL, low DATA_WIDTH bits of A*B.
  - 1011 DIVU and 1101 REMU, only when the optional feature is enabled.
  - All other codes produce result 0, single-cycle.
- Shifts use B[SHAMT_WIDTH-1:0] only; upper B bits are ignored.
- ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow flag.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: Ready_o=1. Start_i=1 latches op/A/B.
    - Single-cycle op: go to DONE.
    - MUL/DIVU/REMU: go to BUSY, iteration counter=DATA_WIDTH-1.
  - BUSY: Ready_o=0. One shift-add (or restore-subtract) step per clock, counter decrements. At counter==0, go to DONE.
  - DONE: result and Zero registered this edge; Valid_o=1 for exactly this cycle; Ready_o=0. Next state is always IDLE.
- Latency, counted from the accepting edge to the edge that asserts Valid_o:
  - single-cycle ops: 1 clock.
  - MUL/DIVU/REMU: DATA_WIDTH+1 clocks.
- Back-to-back throughput for single-cycle ops is one op per 2 clocks: IDLE then DONE.
- Start_i while Ready_o=0 is ignored, not queued. Operand changes during BUSY have no effect.
- Asynchronous reset (reset=0), including mid-operation:
  - FSM goes to IDLE and the operation is abandoned.
  - ALU_Result_o=0, Zero_o=1, Valid_o=0, Ready_o=1.
  - Internal accumulators/counter are cleared.
- ALU_Result_o and Zero_o change only on the Valid_o edge and are stable otherwise.

Optional Feature:
- Macro ALU_SEQ_DIV_EN.
- Defined:
  - DIVU/REMU use the iterative restoring divider, sharing the BUSY counter; unsigned operands; latency DATA_WIDTH+1.
  - Divide by zero (RISC-V rule): DIVU result all-ones, REMU result A.
  - Divide by zero still takes the full latency.
- Undefined:
  - The divider logic is absent.
  - 1011/1101 fall to the default: result 0, Zero_o=1, 1-clock latency.

Test Plan:
- Reset released, then Start_i ADD A=5 B=-7 → Valid_o pulse 1 clock later; Result=32'hFFFFFFFE; Zero_o=0; Ready_o low in DONE, high next cycle.
- SUB A=9 B=9 → Result 0, Zero_o=1. SLT A=-1 B=1 → 1. SLTU A=-1 B=1 → 0.
- SRA A=32'h80000000 B=32'h00000024 (shamt=4) → 32'hF8000000. SLL A=1 B=31 → 32'h80000000. LUI B=32'h12345 → 32'h12345000.
- MUL A=32'hFFFFFFFF B=3 → Valid_o exactly 33 clocks after accept; Result 32'hFFFFFFFD. Start_i pulsed during BUSY is ignored.
- MUL started, reset pulsed low at BUSY cycle 10 → outputs at reset values immediately. After release, ADD 1+1 completes normally with Result 2.
- With ALU_SEQ_DIV_EN: DIVU 100/7 → 14 and REMU → 2, each 33 clocks; DIVU 5/0 → 32'hFFFFFFFF; REMU 5/0 → 5. Without it: DIVU 100/7 → 0 after 1 clock.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with start/valid handshake and a bit-serial multiplier.
// Define ALU_SEQ_DIV_EN to add the iterative restoring divider for DIVU/REMU.
module alu_seq #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  Ready_o,
    output logic                  Valid_o,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o
);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpAnd  = 4'b0010;
    localparam logic [3:0] OpXor  = 4'b0011;
    localparam logic [3:0] OpSlt  = 4'b0100;
    localparam logic [3:0] OpSltu = 4'b0101;
    localparam logic [3:0] OpSrl  = 4'b0110;
    localparam logic [3:0] OpSra  = 4'b0111;
    localparam logic [3:0] OpLui  = 4'b1000;
    localparam logic [3:0] OpOr   = 4'b1001;
    localparam logic [3:0] OpMul  = 4'b1010;
    localparam logic [3:0] OpSll  = 4'b1100;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OpDivu = 4'b1011;
    localparam logic [3:0] OpRemu = 4'b1101;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                  state_q;
    logic [3:0]              op_q;
    logic [SHAMT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0]   acc_q, opa_q, opb_q;
    logic [DATA_WIDTH-1:0]   acc_d, opa_d, opb_d;
    logic [DATA_WIDTH-1:0]   result_q;
    logic                    ready_q, valid_q, zero_q;
    logic [DATA_WIDTH-1:0]   comb_res, fin_res;
    logic                    is_iter;
    logic [SHAMT_WIDTH-1:0]  shamt;

    assign shamt = B_i[SHAMT_WIDTH-1:0];

    always_comb begin
        comb_res = '0;
        case (ALU_Operation_i)
            OpAdd:   comb_res = A_i + B_i;
            OpSub:   comb_res = A_i - B_i;
            OpAnd:   comb_res = A_i & B_i;
            OpXor:   comb_res = A_i ^ B_i;
            OpOr:    comb_res = A_i | B_i;
            OpSlt:   comb_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(A_i) < $signed(B_i))};
            OpSltu:  comb_res = {{(DATA_WIDTH-1){1'b0}}, (A_i < B_i)};
            OpSrl:   comb_res = A_i >> shamt;
            OpSra:   comb_res = $signed(A_i) >>> shamt;
            OpSll:   comb_res = A_i << shamt;
            OpLui:   comb_res = {B_i[DATA_WIDTH-13:0], 12'b0};
            default: comb_res = '0;
        endcase
    end

    always_comb begin
        is_iter = (ALU_Operation_i == OpMul);
`ifdef ALU_SEQ_DIV_EN
        is_iter = is_iter || (ALU_Operation_i == OpDivu) || (ALU_Operation_i == OpRemu);
`endif
    end

`ifdef ALU_SEQ_DIV_EN
    // Restoring divide: acc holds the partial remainder, opa shifts the dividend out / quotient in.
    logic [DATA_WIDTH:0] rem_shift, rem_diff;
    assign rem_shift = {acc_q, opa_q[DATA_WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, opb_q};
`endif

    always_comb begin
        acc_d = acc_q;
        opa_d = opa_q;
        opb_d = opb_q;
        case (op_q)
            OpMul: begin
                if (opb_q[0]) acc_d = acc_q + opa_q;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
            end
`ifdef ALU_SEQ_DIV_EN
            OpDivu, OpRemu: begin
                if (!rem_diff[DATA_WIDTH]) begin
                    acc_d = rem_diff[DATA_WIDTH-1:0];
                    opa_d = {opa_q[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_shift[DATA_WIDTH-1:0];
                    opa_d = {opa_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        fin_res = acc_d;
`ifdef ALU_SEQ_DIV_EN
        if (op_q == OpDivu) fin_res = opa_d;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            op_q     <= OpAdd;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (Start_i) begin
                        op_q    <= ALU_Operation_i;
                        ready_q <= 1'b0;
                        if (is_iter) begin
                            state_q <= StBusy;
                            cnt_q   <= SHAMT_WIDTH'(DATA_WIDTH - 1);
                            acc_q   <= '0;
                            opa_q   <= A_i;
                            opb_q   <= B_i;
                        end else begin
                            state_q  <= StDone;
                            result_q <= comb_res;
                            zero_q   <= (comb_res == '0);
                            valid_q  <= 1'b1;
                        end
                    end
                end
                StBusy: begin
                    acc_q <= acc_d;
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                    cnt_q <= cnt_q - SHAMT_WIDTH'(1);
                    // Last step lands straight in the result register.
                    if (cnt_q == '0) begin
                        state_q  <= StDone;
                        result_q <= fin_res;
                        zero_q   <= (fin_res == '0);
                        valid_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign Ready_o      = ready_q;
    assign Valid_o      = valid_q;
    assign ALU_Result_o = result_q;
    assign Zero_o       = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq; honours ALU_SEQ_DIV_EN like the design.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         Start_i;
    logic [3:0]   ALU_Operation_i;
    logic [W-1:0] A_i;
    logic [W-1:0] B_i;
    logic         Ready_o;
    logic         Valid_o;
    logic [W-1:0] ALU_Result_o;
    logic         Zero_o;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    alu_seq #(.DATA_WIDTH(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .Start_i         (Start_i),
        .ALU_Operation_i (ALU_Operation_i),
        .A_i             (A_i),
        .B_i             (B_i),
        .Ready_o         (Ready_o),
        .Valid_o         (Valid_o),
        .ALU_Result_o    (ALU_Result_o),
        .Zero_o          (Zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a & b;
            4'b0011: r = a ^ b;
            4'b1001: r = a | b;
            4'b0100: r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'b0101: r = (a < b) ? 1 : 0;
            4'b0110: r = a >> b[4:0];
            4'b0111: r = $signed(a) >>> b[4:0];
            4'b1100: r = a << b[4:0];
            4'b1000: r = {b[19:0], 12'h000};
            4'b1010: r = a * b;
`ifdef ALU_SEQ_DIV_EN
            4'b1011: r = (b == 0) ? '1 : a / b;
            4'b1101: r = (b == 0) ? a : a % b;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
        if (op == 4'b1011 || op == 4'b1101) return W + 1;
`endif
        return (op == 4'b1010) ? W + 1 : 1;
    endfunction

    // Issue one op, then wait (bounded) for Valid_o and score it; poke re-pulses Start_i while busy.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input int exp_lat, input bit poke);
        exp_t e;
        int   lat;
        @(negedge clk);
        check({tag, "_ready_idle"}, Ready_o, 1);
        Start_i = 1'b1;
        ALU_Operation_i = op;
        A_i = a;
        B_i = b;
        e.res = exp_res;
        e.lat = exp_lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        Start_i = 1'b0;
        lat = 1;
        while (!Valid_o && lat < 200) begin
            if (poke && lat == 5) begin
                Start_i = 1'b1;
                ALU_Operation_i = 4'b0000;
                A_i = 32'h1;
                B_i = 32'h1;
            end else if (poke && lat == 6) begin
                Start_i = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        Start_i = 1'b0;
        if (!Valid_o) begin
            check({tag, "_timeout"}, Valid_o, 1);
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_res"}, ALU_Result_o, e.res);
        check({tag, "_zero"}, Zero_o, (e.res == 0));
        check({tag, "_lat"}, lat, e.lat);
        check({tag, "_ready_done"}, Ready_o, 0);
        @(posedge clk);
        #1;
        check({tag, "_valid_pulse"}, Valid_o, 0);
        check({tag, "_ready_after"}, Ready_o, 1);
        check({tag, "_hold"}, ALU_Result_o, e.res);
    endtask

    logic [3:0] rnd_ops[14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                4'h7, 4'h8, 4'h9, 4'hA, 4'hC, 4'hB, 4'hD};

    initial begin
        reset = 1'b0;
        Start_i = 1'b0;
        ALU_Operation_i = '0;
        A_i = '0;
        B_i = '0;
        #12;
        check("rst_ready", Ready_o, 1);
        check("rst_valid", Valid_o, 0);
        check("rst_result", ALU_Result_o, 0);
        check("rst_zero", Zero_o, 1);
        @(negedge clk);
        reset = 1'b1;

        run_op("add", 4'b0000, 32'd5, -32'sd7, 32'hFFFF_FFFE, 1, 0);
        run_op("sub", 4'b0001, 32'd9, 32'd9, 32'h0, 1, 0);
        run_op("slt", 4'b0100, 32'hFFFF_FFFF, 32'd1, 32'h1, 1, 0);
        run_op("sltu", 4'b0101, 32'hFFFF_FFFF, 32'd1, 32'h0, 1, 0);
        run_op("sra", 4'b0111, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, 0);
        run_op("sll", 4'b1100, 32'd1, 32'd31, 32'h8000_0000, 1, 0);
        run_op("lui", 4'b1000, 32'd0, 32'h0001_2345, 32'h1234_5000, 1, 0);
        run_op("undef", 4'b1110, 32'd3, 32'd4, 32'h0, 1, 0);
        run_op("mul", 4'b1010, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 33, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("no_extra_valid", Valid_o, 0);
        end

`ifdef ALU_SEQ_DIV_EN
        run_op("divu", 4'b1011, 32'd100, 32'd7, 32'd14, 33, 0);
        run_op("remu", 4'b1101, 32'd100, 32'd7, 32'd2, 33, 0);
        run_op("divu0", 4'b1011, 32'd5, 32'd0, 32'hFFFF_FFFF, 33, 0);
        run_op("remu0", 4'b1101, 32'd5, 32'd0, 32'd5, 33, 0);
`else
        run_op("divu_off", 4'b1011, 32'd100, 32'd7, 32'h0, 1, 0);
        run_op("remu_off", 4'b1101, 32'd100, 32'd7, 32'h0, 1, 0);
`endif

        // Reset in the middle of a multiply.
        @(negedge clk);
        Start_i = 1'b1;
        ALU_Operation_i = 4'b1010;
        A_i = 32'h1234_5678;
        B_i = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        Start_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_ready", Ready_o, 1);
        check("midrst_valid", Valid_o, 0);
        check("midrst_result", ALU_Result_o, 0);
        check("midrst_zero", Zero_o, 1);
        @(negedge clk);
        reset = 1'b1;
        run_op("post_rst_add", 4'b0000, 32'd1, 32'd1, 32'd2, 1, 0);

        for (int i = 0; i < 10; i++) begin
            logic [3:0]   op;
            logic [W-1:0] a, b;
            op = rnd_ops[$urandom_range(13, 0)];
            a = $urandom;
            b = (i % 3 == 0) ? W'($urandom_range(40, 0)) : $urandom;
            run_op($sformatf("rnd%0d_op%0h", i, op), op, a, b, ref_alu(op, a, b), ref_lat(op), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
